seq_array_multiplier: RTL and testbench
=======================================

// Module: seq_array_multiplier
// PURPOSE
//  Iterative 16x16 unsigned multiplier. One row of a Braun carry-save array per clock,
//  using a single instance of the 15-bit full-adder row MultiAdd15, then a final
//  16-bit resolve add. Sits upstream of the adder row: it generates the partial-product
//  rows and feeds them in, then consumes the sum and carry vectors the row returns.
//  Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  WIDTH   16   operand width. Only 16 is supported (fixed by the 15-bit adder row);
//               elaboration error otherwise.
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   block can accept operands
//  a          in   16  multiplicand
//  b          in   16  multiplier
//  out_valid  out  1   product valid
//  out_ready  in   1   consumer accepts product
//  product    out  32  a*b, unsigned
//  busy       out  1   operation in progress (state != IDLE)
// BEHAVIOUR
//  Reset: rst_n=0 sampled at posedge -> state=IDLE, S=0, C=0, row=0, product=0,
//   out_valid=0, busy=0; in_ready=1 from next cycle. Applies mid-operation;
//   the pending result is discarded.
//  FSM states: IDLE -> ROW -> FINAL -> DONE -> IDLE.
//  IDLE
//   - in_ready=1.
//   - On in_valid: latch a,b; S <= a & {16{b[0]}}; C <= 0; product[0] <= a[0]&b[0];
//     row <= 1; go to ROW.
//  ROW (row = 1..15)
//   - pp = a & {16{b[row]}}.
//   - Adder row inputs: x = S[15:1], y = pp[14:0], cin = C.
//   - S <= {pp[15], sum}; C <= cout; product[row] <= sum[0].
//   - row==15 -> FINAL; otherwise row++.
//  FINAL
//   - product[31:16] <= {1'b0,S[15:1]} + {1'b0,C}.
//   - This add cannot overflow 16 bits; no carry out is kept.
//   - Go to DONE.
//  DONE
//   - out_valid=1; product is stable.
//   - On out_ready: go to IDLE.
//  Latency
//   - Accept edge = E0. Rows occupy E1..E15; FINAL is E16.
//   - out_valid is high after E16: 16 cycles from accept to first out_valid.
//  Handshake
//   - Transfer occurs when valid && ready at a posedge.
//   - out_valid, once high, holds with product constant until out_ready.
//   - in_ready=0 in ROW/FINAL/DONE; in_valid is ignored there (operands are not queued).
//   - in_ready rises the cycle after the output handshake, so no same-cycle in/out overlap.
//   - Minimum issue interval is 18 cycles.
//  Registers
//   - product bits are written progressively. The consumer reads product only
//     while out_valid=1.
//   - Inputs a and b may change after acceptance without effect.
// TESTING
//  1. a=0x0003, b=0x0005, out_ready=1 -> out_valid exactly 16 cycles after accept;
//     product=0x0000000F.
//  2. a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 (max carry propagation).
//  3. a=0x1234, b=0x5678 -> 0x06260060. Also a=0, b=0xBEEF -> 0x00000000.
//  4. out_ready=0 for 10 cycles after out_valid -> out_valid and product held;
//     in_ready=0; a second in_valid with new operands is not accepted until after
//     the output handshake.
//  5. rst_n=0 at row 7 of a=0xFFFF, b=0xFFFF -> next cycle busy=0, out_valid=0,
//     product=0; the following a=2, b=3 yields 0x00000006.
//  6. Random 10k unsigned pairs with random out_ready backpressure vs a*b reference
//     model -> zero mismatches.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// -----------------------------------------------------------------------------
// seq_array_multiplier
//   Iterative 16x16 unsigned multiplier built around a single 15-bit
//   carry-save full-adder row (MultiAdd15). One partial-product row of a
//   Braun array is folded in per clock. A final 16-bit add then resolves
//   the remaining sum/carry vectors into the upper product half.
//   Only one operation can be in flight at a time.
//
// Ports (seq_array_multiplier)
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    operands valid
//   in_ready   out  1    block can accept operands (IDLE only)
//   a          in   16   multiplicand
//   b          in   16   multiplier
//   out_valid  out  1    product valid (held until out_ready)
//   out_ready  in   1    consumer accepts product
//   product    out  32   a*b, unsigned
//   busy       out  1    operation in progress
// -----------------------------------------------------------------------------

// 15-bit row of independent full adders (carry-save, no ripple).
module MultiAdd15 (
  input  logic [14:0] x,
  input  logic [14:0] y,
  input  logic [14:0] cin,
  output logic [14:0] sum,
  output logic [14:0] cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

module seq_array_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // The adder row is fixed at 15 bits, so only a 16-bit operand fits.
  generate
    if (WIDTH != 16) begin : gWidthCheck
      $error("seq_array_multiplier: WIDTH must be 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT              stateQ;
  stateT              stateD;
  logic               accept;

  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [WIDTH-1:0]   sReg;       // running sum vector, bit 0 retires each row
  logic [WIDTH-2:0]   cReg;       // running carry vector, aligned with sReg[15:1]
  logic [3:0]         rowQ;
  logic [2*WIDTH-1:0] productQ;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH-2:0]   rowSum;
  logic [WIDTH-2:0]   rowCout;
  logic [WIDTH-1:0]   highSum;

  // Partial product of the current multiplier bit.
  assign pp = aReg & {WIDTH{bReg[rowQ]}};

  MultiAdd15 uAddRow (
    .x    (sReg[WIDTH-1:1]),
    .y    (pp[WIDTH-2:0]),
    .cin  (cReg),
    .sum  (rowSum),
    .cout (rowCout)
  );

  // Both vectors carry weight 2^16 at bit 0 here; a 15+15-bit sum fits in 16.
  assign highSum = {1'b0, sReg[WIDTH-1:1]} + {1'b0, cReg};

  assign product = productQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept = 1'b1;
          stateD = ROW;
        end
      end
      ROW: begin
        if (rowQ == 4'd15) begin
          stateD = FINAL;
        end
      end
      FINAL: begin
        stateD = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aReg     <= '0;
      bReg     <= '0;
      sReg     <= '0;
      cReg     <= '0;
      rowQ     <= '0;
      productQ <= '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (accept) begin
            aReg     <= a;
            bReg     <= b;
            sReg     <= a & {WIDTH{b[0]}};
            cReg     <= '0;
            rowQ     <= 4'd1;
            productQ <= {{(2*WIDTH-1){1'b0}}, a[0] & b[0]};
          end
        end
        ROW: begin
          // Low sum bit is final at this weight; the rest shifts down a place.
          sReg           <= {pp[WIDTH-1], rowSum};
          cReg           <= rowCout;
          productQ[rowQ] <= rowSum[0];
          if (rowQ != 4'd15) begin
            rowQ <= rowQ + 4'd1;
          end
        end
        FINAL: begin
          productQ[2*WIDTH-1:WIDTH] <= highSum;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
module tb_seq_array_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_array_multiplier #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for acceptance, then scramble the inputs.
  task automatic startOp(input logic [15:0] av, input logic [15:0] bv);
    int w;
    w = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic runOp(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] expP,
                       input int hold, input string tag, input bit checkLat);
    int cyc;
    out_ready = (hold == 0);
    startOp(av, bv);
    waitValid(cyc);
    if (checkLat) check({tag, "_latency"}, 32'(cyc), 32'd16);
    check({tag, "_product"}, product, expP);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_product"}, product, expP);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_product", product, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic products and latency
    runOp(16'h0003, 16'h0005, 32'h0000000F, 0, "t1", 1'b1);
    runOp(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, "t2", 1'b1);
    runOp(16'h1234, 16'h5678, 32'h06260060, 1, "t3a", 1'b1);
    runOp(16'h0000, 16'hBEEF, 32'h00000000, 0, "t3b", 1'b0);
    runOp(16'h8000, 16'h8000, 32'h40000000, 2, "t3c", 1'b0);
    runOp(16'hFFFF, 16'h0001, 32'h0000FFFF, 0, "t3d", 1'b0);

    // Backpressure with a competing request while the result is pending
    out_ready = 1'b0;
    startOp(16'h00FF, 16'h0101);
    waitValid(cyc);
    check("t4_latency", 32'(cyc), 32'd16);
    in_valid = 1'b1;
    a = 16'h0007;
    b = 16'h0009;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t4_hold_product", product, 32'h0000FFFF);
      check("t4_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_after_hs_in_ready", {31'b0, in_ready}, 32'd1);
    check("t4_after_hs_busy", {31'b0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t4_second_busy", {31'b0, busy}, 32'd1);
    waitValid(cyc);
    check("t4_second_latency", 32'(cyc), 32'd16);
    check("t4_second_product", product, 32'h0000003F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of an operation
    startOp(16'hFFFF, 16'hFFFF);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_product", product, 32'h0);
    rst_n = 1'b1;
    runOp(16'h0002, 16'h0003, 32'h00000006, 0, "t5_after", 1'b1);

    // Short run of random pairs with random backpressure
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      runOp(ra, rb, {16'h0, ra} * {16'h0, rb}, int'($urandom_range(0, 3)), "rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
